// File: rtl/ppe_pkg.sv
// Shared PPE network definitions: opcodes, node ids, packet layout.
// Also holds the responder FSM state type.
package ppe_pkg;

  localparam logic [3:0] OP_WEIGHT               = 4'd0;
  localparam logic [3:0] OP_INPUT                = 4'd1;
  localparam logic [3:0] OP_HAS_INPUTS           = 4'd2;
  localparam logic [3:0] OP_DOES_NOT_HAVE_INPUTS = 4'd3;
  localparam logic [3:0] OP_REQ_INPUTS           = 4'd4;
  localparam logic [3:0] OP_TIMESTEP_DONE        = 4'd15;

  localparam logic [3:0] IMEM_ID = 4'd11;

  localparam int PKT_W    = 33;
  localparam int ADDR_MSB = 32;
  localparam int ADDR_LSB = 29;
  localparam int OP_MSB   = 28;
  localparam int OP_LSB   = 25;
  localparam int DATA_MSB = 24;
  localparam int DATA_LSB = 0;
  localparam int ROW_W    = 5;

  typedef struct packed {
    logic [3:0]  addr;
    logic [3:0]  opcode;
    logic [24:0] data;
  } packet_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_SEND
  } state_e;

endpackage

// File: rtl/imem_row_responder_req_fifo.sv
// Request queue: synchronous FIFO of whole packets.
// Pointers carry one wrap bit so full and empty are distinguishable.
module req_fifo
  import ppe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push_i,
  input  packet_t data_i,
  input  logic    pop_i,
  output packet_t data_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AW = $clog2(DEPTH);

  packet_t        mem_q [DEPTH];
  logic    [AW:0] wr_q;
  logic    [AW:0] rd_q;
  logic           do_push;
  logic           do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/imem_row_responder.sv
// Input-memory endpoint: queues row requests and answers each
// with the stored ifmap row of the current timestep.
module imem_row_responder
  import ppe_pkg::*;
#(
  parameter int IFMAP_SIZE = 25,
  parameter int NUM_TS     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int NODE_ID    = int'(IMEM_ID)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [32:0] in_packet,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:0] out_packet,
  input  logic        load_en,
  input  logic        load_ts,
  input  logic [4:0]  load_row,
  input  logic [24:0] load_data,
  output logic        cur_ts,
  output logic [7:0]  err_count
);

  packet_t     in_pkt;
  packet_t     head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        drop;
  logic        bad;
  logic        row_ok;
  logic [24:0] rd_bits;
  logic        ts_next;
  logic [1:0]  err_inc;
  logic [8:0]  err_sum;
  logic [23:0] unused_head;

  state_e      state_q, state_d;
  logic [3:0]  req_q, req_d;
  logic [4:0]  row_q, row_d;
  logic        ts_q, ts_d;
  logic        ov_q, ov_d;
  logic [32:0] pkt_q, pkt_d;
  logic [7:0]  err_q, err_d;

  logic [24:0] mem_q [NUM_TS][IFMAP_SIZE];

  assign in_pkt   = packet_t'(in_packet);
  assign in_ready = !fifo_full;
  assign drop     = in_valid && in_ready &&
                    (in_pkt.addr != 4'(NODE_ID));
  assign push     = in_valid && in_ready && !drop;

  req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (in_pkt),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Only the row field and requester matter once a packet is queued.
  assign unused_head = {head.addr, head.data[24:5]};

  assign row_ok  = int'(row_q) < IFMAP_SIZE;
  assign rd_bits = row_ok ? mem_q[ts_q][row_q] : '0;
  assign ts_next = (ts_q == 1'(NUM_TS-1)) ? 1'b0 : ts_q + 1'b1;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    row_d   = row_q;
    ts_d    = ts_q;
    ov_d    = ov_q;
    pkt_d   = pkt_q;
    pop     = 1'b0;
    bad     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head.opcode == OP_TIMESTEP_DONE) begin
            ts_d = ts_next;
          end else begin
            req_d   = head.opcode;
            row_d   = head.data[4:0];
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        ov_d    = 1'b1;
        state_d = ST_SEND;
        if (row_ok) begin
          pkt_d = {req_q, OP_INPUT, rd_bits};
        end else begin
          pkt_d = {req_q, OP_DOES_NOT_HAVE_INPUTS, 25'd0};
          bad   = 1'b1;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A dropped packet and a bad row can land on the same edge.
    err_inc = {1'b0, drop} + {1'b0, bad};
    err_sum = 9'(err_q) + 9'(err_inc);
    err_d   = (err_sum > 9'd255) ? 8'd255 : err_sum[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      row_q   <= '0;
      ts_q    <= 1'b0;
      ov_q    <= 1'b0;
      pkt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      row_q   <= row_d;
      ts_q    <= ts_d;
      ov_q    <= ov_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_en && (int'(load_row) < IFMAP_SIZE))
      mem_q[load_ts][load_row] <= load_data;
  end

  assign out_valid  = ov_q;
  assign out_packet = pkt_q;
  assign cur_ts     = ts_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_imem_row_responder.sv
// Directed and random checks of imem_row_responder against
// a queue-based model of the row request protocol.
module tb_imem_row_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] in_packet;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_packet;
  logic        load_en;
  logic        load_ts;
  logic [4:0]  load_row;
  logic [24:0] load_data;
  logic        cur_ts;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  imem_row_responder dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_packet  (in_packet),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_packet (out_packet),
    .load_en    (load_en),
    .load_ts    (load_ts),
    .load_row   (load_row),
    .load_data  (load_data),
    .cur_ts     (cur_ts),
    .err_count  (err_count)
  );

  int          checks = 0;
  int          errors = 0;
  int          sink_mode = 0;
  logic [24:0] mem_m [2][25];
  logic [32:0] exp_q [$];
  int          ts_m = 0;
  int          err_m = 0;
  logic        hold = 1'b0;
  logic [32:0] held;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_accept(logic [32:0] p);
    logic [3:0] d   = p[32:29];
    logic [3:0] op  = p[28:25];
    int         row = int'(p[4:0]);
    if (d != 4'd11) begin
      err_m = (err_m + 1 > 255) ? 255 : err_m + 1;
    end else if (op == 4'd15) begin
      ts_m = (ts_m + 1) % 2;
    end else if (row >= 25) begin
      exp_q.push_back({op, 4'd3, 25'd0});
      err_m = (err_m + 1 > 255) ? 255 : err_m + 1;
    end else begin
      exp_q.push_back({op, 4'd1, mem_m[ts_m][row]});
    end
  endfunction

  task automatic send(logic [3:0] d, logic [3:0] op, logic [24:0] dat);
    int n = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_packet = {d, op, dat};
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept({d, op, dat});
    #1 in_valid = 1'b0;
  endtask

  task automatic load(logic ts, logic [4:0] row, logic [24:0] d);
    @(negedge clk);
    load_en   = 1'b1;
    load_ts   = ts;
    load_row  = row;
    load_data = d;
    @(posedge clk);
    if (row < 5'd25) mem_m[ts][row] = d;
    #1 load_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  // Sink: picks out_ready at each falling edge and checks responses.
  always @(negedge clk) begin
    if (reset) begin
      hold      = 1'b0;
      out_ready = 1'b0;
    end else begin
      if (hold)
        chk("hold", 64'({out_valid, out_packet}), 64'({1'b1, held}));
      out_ready = (sink_mode == 1) ||
                  (sink_mode == 2 && $urandom_range(0, 1) == 1);
      hold = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0)
          chk("spurious", 64'(out_valid), 64'd0);
        else
          chk("resp", 64'(out_packet), 64'(exp_q.pop_front()));
      end else if (out_valid) begin
        hold = 1'b1;
        held = out_packet;
      end
    end
  end

  initial begin
    int          n;
    logic [24:0] nd;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_packet = '0;
    load_en   = 1'b0;
    load_ts   = 1'b0;
    load_row  = '0;
    load_data = '0;
    for (int t = 0; t < 2; t++)
      for (int r = 0; r < 25; r++) mem_m[t][r] = '0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_packet", 64'(out_packet), 64'd0);
    chk("rst_cur_ts", 64'(cur_ts), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < 2; t++)
      for (int r = 0; r < 25; r++) load(t[0], 5'(r), '0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Row fetch latency and held response
    load(1'b0, 5'd7, 25'h1A5A5A5);
    sink_mode = 0;
    send(4'd11, 4'd9, 25'd7);
    @(negedge clk);
    chk("lat_n1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_n2", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("t1_pkt", 64'(out_packet), 64'({4'd9, 4'd1, 25'h1A5A5A5}));
    repeat (5) @(negedge clk);
    sink_mode = 1;
    drain();
    chk("t2_idle", 64'(out_valid), 64'd0);

    // Burst into a stalled sink fills the queue
    sink_mode = 0;
    for (int i = 0; i < 5; i++) send(4'd11, 4'(i + 2), 25'(i));
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    sink_mode = 1;
    send(4'd11, 4'd12, 25'd5);
    drain();

    // Bad row and wrong destination
    send(4'd11, 4'd5, 25'd30);
    send(4'd4, 4'd5, 25'd0);
    drain();
    chk("t4_err", 64'(err_count), 64'd2);

    // Timestep advance keeps arrival order
    load(1'b1, 5'd0, 25'd1);
    load(1'b0, 5'd0, 25'd0);
    send(4'd11, 4'd8, 25'd0);
    send(4'd11, 4'd15, 25'h155);
    send(4'd11, 4'd8, 25'd0);
    drain();
    chk("t5_ts", 64'(cur_ts), 64'd1);

    // Load landing on the READ edge must not affect that read
    send(4'd11, 4'd6, 25'd3);
    @(negedge clk);
    @(negedge clk);
    nd        = 25'h0ABCDEF;
    load_en   = 1'b1;
    load_ts   = ts_m[0];
    load_row  = 5'd3;
    load_data = nd;
    @(posedge clk);
    mem_m[ts_m][3] = nd;
    #1 load_en = 1'b0;
    drain();
    send(4'd11, 4'd6, 25'd3);
    drain();

    // Random traffic over fresh storage
    for (int t = 0; t < 2; t++)
      for (int r = 0; r < 25; r++) load(t[0], 5'(r), 25'($urandom));
    load(1'b0, 5'd27, 25'h1FFFFFF);
    sink_mode = 2;
    for (int i = 0; i < 80; i++) begin
      logic [3:0] d;
      logic [3:0] op;
      d  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 10)) : 4'd11;
      op = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      send(d, op, 25'($urandom_range(0, 31)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    chk("rand_err", 64'(err_count), 64'(err_m));
    chk("rand_ts", 64'(cur_ts), 64'(ts_m));

    // Error counter saturation
    for (int i = 0; i < 260; i++) send(4'd3, 4'd1, 25'd0);
    drain();
    chk("err_sat", 64'(err_count), 64'd255);

    // Reset while a response is held
    sink_mode = 0;
    send(4'd11, 4'd9, 25'd7);
    send(4'd11, 4'd2, 25'd1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_send", 64'(out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_out_packet", 64'(out_packet), 64'd0);
    chk("t6_err", 64'(err_count), 64'd0);
    chk("t6_ts", 64'(cur_ts), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    ts_m  = 0;
    err_m = 0;
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b0;
    sink_mode = 1;
    repeat (10) @(negedge clk);
    chk("t6_queue_empty", 64'(out_valid), 64'd0);
    send(4'd11, 4'd9, 25'd7);
    drain();
    chk("t6_err_after", 64'(err_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
